regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32 x 64-bit register file between several writeback requesters (ALU, load unit, multiplier) using round-robin arbitration and a valid/ready handshake. Granted writes are registered and driven onto the register file's `write`/`address`/`data_in` inputs one cycle later. A per-register busy vector is exported so decode can stall on pending writes.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..4.
- `ADDR_WIDTH`, default 5: register address width.
- `DATA_WIDTH`, default 64: register data width.

- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a write pending.
- `req_address`  in  NUM_REQ*ADDR_WIDTH  destination of requester i, slice i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  write data of requester i, slice i.
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when valid & ready.
- `rf_write`  out  1  to register file `write`.
- `rf_address`  out  ADDR_WIDTH  to register file `address`.
- `rf_data`  out  DATA_WIDTH  to register file `data_in`.
- `busy`  out  32  bit a set while any write to register a is pending or in the output stage.
- `last_grant`  out  2  index of the most recently accepted requester.

## Operation
- Round-robin pointer `ptr` (0..NUM_REQ-1). Each cycle, search from `ptr` upward with wrap. The first requester with `req_valid` set gets `req_ready` high, combinationally in the same cycle.
- At most one `req_ready` bit high per cycle. None high if no valid request or reset low.
- On transfer from requester g:
  - Next edge: `rf_write`=1, `rf_address`/`rf_data` = g's slice.
  - `ptr` = (g+1) mod NUM_REQ.
  - `last_grant` = g.
- No transfer: next edge `rf_write`=0, `rf_address`/`rf_data` hold their previous values, `ptr` unchanged.
- Requester rules:
  - Hold valid, address and data stable until ready.
  - Valid must not depend on ready.
  - Deasserting valid before the grant is illegal.
- The output stage always drains because the register file accepts every cycle. Throughput is one write per cycle.
- Same address from two requesters in one cycle: serialized in round-robin order. The later grant overwrites the earlier one, one cycle apart.
- `busy[a]` = OR over i of (`req_valid[i]` & `req_address[i]`==a), OR (`rf_write` & `rf_address`==a). Combinational.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.

## Timing
- Reset (async, `reset`=0):
  - `rf_write`=0, `rf_address`=0, `rf_data`=0, `ptr`=0, `last_grant`=0.
  - `req_ready`=0 while reset is low.
  - `busy` reflects only `req_valid` terms.
- Reset asserted mid-operation: any write in the output stage is dropped immediately (`rf_write` falls asynchronously). Requests not yet transferred stay pending and are arbitrated from `ptr`=0 after release.
- Latency:
  - Accept edge E: data registered.
  - `rf_write` high during cycle E..E+1.
  - Register file captures at E+1.
  - Value readable on `out_a`/`out_b` after E+1.
- First grant after reset release is possible in the first cycle `reset` is high.

## Configuration
- `REGWR_XZR_DROP_EN` defined:
  - Address 31 is the zero register.
  - A request to 31 is still granted (`req_ready` high, `ptr`/`last_grant` advance).
  - `rf_write` stays 0 on the next cycle.
  - `busy[31]` is constant 0.
- Undefined: address 31 is written like any other register.

## Structure
- Package `regfile_pkg`: `REG_COUNT`=32, `REG_ADDR_WIDTH`=5, `REG_DATA_WIDTH`=64, `XZR_ADDR`=31.
- Sub-module `rr_arbiter`:
  - Inputs: NUM_REQ request vector, `ptr`.
  - Outputs: one-hot grant, encoded index, `any`.
  - Purely combinational.
  - The top level owns `ptr`, the output register and the busy logic.

## Test plan
- Reset then idle: all `req_valid`=0 → `rf_write`=0, `req_ready`=0, `busy`=0, `rf_address`=0 for 10 cycles.
- Single request: req0 valid, addr 5, data 64'hDEADBEEF_00000001 → `req_ready[0]`=1 that cycle; next cycle `rf_write`=1, `rf_address`=5; `busy[5]` high for exactly 2 cycles.
- Three requesters continuously valid (addrs 1, 2, 3) from `ptr`=0 → grants 0,1,2,0,1,2; `rf_address` 1,2,3,1,2,3; one write per cycle.
- Same address 7 from req1 (data A) and req2 (data B), `ptr`=2 → req2 granted first, then req1; register 7 ends at A.
- Async reset asserted while `rf_write`=1 → `rf_write`=0 before the next edge, `ptr`=0. After release, pending req1 and req2 are granted in order 1, 2.
- With `REGWR_XZR_DROP_EN`: req0 to addr 31 → `req_ready[0]`=1, next cycle `rf_write`=0, `busy[31]`=0. Without the macro: `rf_write`=1, `rf_address`=31.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the 32 x 64-bit register file and its write arbiter,
// plus the round-robin pointer advance helper used by the arbiter top level.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 64;
    localparam int XZR_ADDR       = 31;

    // Next round-robin pointer: one past the granted index, wrapping at num_req.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input logic [2:0] num_req);
        logic [2:0] nxt;
        nxt = {1'b0, idx} + 3'd1;
        return (nxt >= num_req) ? 2'd0 : nxt[1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches the request vector starting
// at ptr and wrapping, and returns the first requester found.
// Ports:
//   req   [NUM_REQ-1:0]  request vector
//   ptr   [1:0]          search start index (must be < NUM_REQ)
//   grant [NUM_REQ-1:0]  one-hot grant (all zero when no request)
//   idx   [1:0]          encoded index of the granted requester
//   any                  at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         idx,
    output logic               any
);

    logic [2:0] cand_s;
    logic       hit_s;

    // First-found search from ptr upward with wrap; later hits are masked by any.
    always_comb begin
        grant  = '0;
        idx    = 2'd0;
        any    = 1'b0;
        cand_s = 3'd0;
        hit_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, ptr} + 3'(k);
            cand_s = (cand_s >= 3'(NUM_REQ)) ? (cand_s - 3'(NUM_REQ)) : cand_s;
            hit_s  = ~any & req[cand_s[1:0]];
            grant[cand_s[1:0]] = grant[cand_s[1:0]] | hit_s;
            idx    = hit_s ? cand_s[1:0] : idx;
            any    = any | hit_s;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between NUM_REQ writeback
// requesters with round-robin arbitration and a valid/ready handshake.
// Accepted writes are registered and presented to the register file one cycle
// later. A per-register busy vector lets decode stall on pending writes.
//
// Optional feature: define REGWR_XZR_DROP_EN to treat address 31 as the zero
// register (requests are still accepted, but no write is issued and busy[31]
// stays low).
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   req_valid    [NUM_REQ]             requester has a write pending
//   req_address  [NUM_REQ*ADDR_WIDTH]  destination, slice i per requester
//   req_data     [NUM_REQ*DATA_WIDTH]  write data, slice i per requester
//   req_ready    [NUM_REQ]             one-hot grant (combinational)
//   rf_write                           register file write enable
//   rf_address   [ADDR_WIDTH]          register file address
//   rf_data      [DATA_WIDTH]          register file data_in
//   busy         [32]                  register has a pending/in-flight write
//   last_grant   [2]                   index of most recently accepted requester
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_write,
    output logic [ADDR_WIDTH-1:0]         rf_address,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic [REG_COUNT-1:0]          busy,
    output logic [1:0]                    last_grant
);

    logic [1:0]            ptr_r;
    logic [1:0]            last_grant_r;
    logic                  rf_write_r;
    logic [ADDR_WIDTH-1:0] rf_address_r;
    logic [DATA_WIDTH-1:0] rf_data_r;

    logic [NUM_REQ-1:0]    arb_grant_s;
    logic [1:0]            arb_idx_s;
    logic                  arb_any_s;
    logic                  transfer_s;
    logic                  write_en_s;
    logic [ADDR_WIDTH-1:0] sel_address_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [REG_COUNT-1:0]  busy_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // No grant is offered while reset is held low, so nothing can transfer.
    assign transfer_s = arb_any_s & reset;
    assign req_ready  = reset ? arb_grant_s : {NUM_REQ{1'b0}};

    // Select the granted requester's address and data slices (one-hot mux).
    always_comb begin
        sel_address_s = '0;
        sel_data_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_address_s = arb_grant_s[i] ? req_address[i*ADDR_WIDTH +: ADDR_WIDTH] : sel_address_s;
            sel_data_s    = arb_grant_s[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH]    : sel_data_s;
        end
    end

    // Decide whether an accepted request actually produces a register write.
    always_comb begin
        write_en_s = 1'b1;
`ifdef REGWR_XZR_DROP_EN
        // Writes to the zero register are accepted but silently discarded.
        write_en_s = (sel_address_s != ADDR_WIDTH'(XZR_ADDR));
`else
        write_en_s = 1'b1;
`endif
    end

    // Output stage and arbitration state; reset drops any in-flight write at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_write_r   <= 1'b0;
            rf_address_r <= '0;
            rf_data_r    <= '0;
            ptr_r        <= 2'd0;
            last_grant_r <= 2'd0;
        end else if (transfer_s) begin
            rf_write_r   <= write_en_s;
            rf_address_r <= sel_address_s;
            rf_data_r    <= sel_data_s;
            ptr_r        <= rr_next(arb_idx_s, 3'(NUM_REQ));
            last_grant_r <= arb_idx_s;
        end else begin
            // Address/data hold; only the strobe drops.
            rf_write_r   <= 1'b0;
        end
    end

    // Busy: any valid request targeting the register, or the write in the output stage.
    always_comb begin
        busy_s = '0;
        for (int a = 0; a < REG_COUNT; a++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                busy_s[a] = busy_s[a] |
                            (req_valid[i] & (req_address[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a)));
            end
            busy_s[a] = busy_s[a] | (rf_write_r & (rf_address_r == ADDR_WIDTH'(a)));
        end
`ifdef REGWR_XZR_DROP_EN
        busy_s[XZR_ADDR] = 1'b0;
`else
        busy_s = busy_s;
`endif
    end

    assign busy       = busy_s;
    assign rf_write   = rf_write_r;
    assign rf_address = rf_address_r;
    assign rf_data    = rf_data_r;
    assign last_grant = last_grant_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Scoreboard bench: each accepted request pushes the expected register-file
// write; a monitor pops and compares one cycle later. Grant and busy values
// come from a small round-robin model driven by the bench's own stimulus.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 64;
`ifdef REGWR_XZR_DROP_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_address = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic             rf_write;
    logic [AW-1:0]    rf_address;
    logic [DW-1:0]    rf_data;
    logic [31:0]      busy;
    logic [1:0]       last_grant;

    int            pend [NR];
    logic [AW-1:0] ta [NR];
    logic [DW-1:0] td [NR];
    logic [1:0]    mptr;
    logic [1:0]    mlast;
    logic          mout_w;
    logic [AW-1:0] mout_a;
    exp_t          sbq [$];
    int            gq [$];
    logic [DW-1:0] rf_mem [32];
    int            n_checks = 0;
    int            n_fail = 0;

    regfile_write_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_address (req_address),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_write    (rf_write),
        .rf_address  (rf_address),
        .rf_data     (rf_data),
        .busy        (busy),
        .last_grant  (last_grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: sample registered outputs 2 ns after the edge and pop the scoreboard.
    always begin
        exp_t e;
        @(posedge clock);
        #2;
        if (rf_write === 1'b1) rf_mem[rf_address] = rf_data;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rf_write", 64'(rf_write), 64'(e.w));
            if (e.w) begin
                check("rf_address", 64'(rf_address), 64'(e.a));
                check("rf_data", rf_data, e.d);
            end
        end else begin
            check("rf_write_idle", 64'(rf_write), 64'd0);
        end
    end

    // One cycle: apply reset level and requests at the falling edge, then check.
    task automatic step(input logic rst_val);
        logic [NR-1:0] exp_ready;
        logic [31:0]   exp_busy;
        int            g;
        exp_t          e;
        @(negedge clock);
        reset = rst_val;
        if (!rst_val) begin
            mptr   = 2'd0;
            mlast  = 2'd0;
            mout_w = 1'b0;
            sbq.delete();
        end
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (pend[i] > 0);
            req_address[i*AW +: AW] = ta[i];
            req_data[i*DW +: DW] = td[i];
        end
        #1;
        exp_ready = '0;
        g = -1;
        if (reset) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (int'(mptr) + k) % NR;
                if (g < 0 && pend[c] > 0) g = c;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end else begin
            check("rf_write_in_reset", 64'(rf_write), 64'd0);
            check("rf_address_in_reset", 64'(rf_address), 64'd0);
        end
        exp_busy = '0;
        for (int i = 0; i < NR; i++) if (pend[i] > 0) exp_busy[ta[i]] = 1'b1;
        if (mout_w) exp_busy[mout_a] = 1'b1;
        if (XZR) exp_busy[31] = 1'b0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(exp_busy));
        check("last_grant", 64'(last_grant), 64'(mlast));
        if (g >= 0) begin
            e.w = !(XZR && ta[g] == 5'd31);
            e.a = ta[g];
            e.d = td[g];
            sbq.push_back(e);
            mout_w = e.w;
            mout_a = ta[g];
            mptr   = 2'((g + 1) % NR);
            mlast  = 2'(g);
            pend[g]--;
            gq.push_back(g);
        end else begin
            mout_w = 1'b0;
        end
    endtask

    initial begin
        int exp_rr [6];
        exp_rr = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0;
            ta[i] = 5'd0;
            td[i] = 64'd0;
        end
        mptr = 2'd0; mlast = 2'd0; mout_w = 1'b0; mout_a = 5'd0;

        // Reset held, then idle for 10 cycles.
        repeat (3) step(1'b0);
        for (int n = 0; n < 10; n++) begin
            step(1'b1);
            check("idle_rf_address", 64'(rf_address), 64'd0);
            check("idle_rf_write", 64'(rf_write), 64'd0);
        end

        // Single request to register 5.
        ta[0] = 5'd5; td[0] = 64'hDEADBEEF_00000001; pend[0] = 1;
        step(1'b1);
        check("single_ready", 64'(req_ready), 64'd1);
        step(1'b1);
        check("single_busy_hold", 64'(busy[5]), 64'd1);
        check("single_rf_address", 64'(rf_address), 64'd5);
        step(1'b1);
        check("single_busy_clear", 64'(busy[5]), 64'd0);

        // Three continuously valid requesters from ptr 0.
        step(1'b0);
        step(1'b1);
        ta[0] = 5'd1; ta[1] = 5'd2; ta[2] = 5'd3;
        td[0] = 64'h1111; td[1] = 64'h2222; td[2] = 64'h3333;
        pend[0] = 2; pend[1] = 2; pend[2] = 2;
        gq.delete();
        repeat (6) step(1'b1);
        step(1'b1);
        check("rr_count", 64'(gq.size()), 64'd6);
        for (int j = 0; j < 6 && j < gq.size(); j++) check("rr_order", 64'(gq[j]), 64'(exp_rr[j]));

        // Same address from req1 (A) and req2 (B) with ptr at 2.
        ta[1] = 5'd9; td[1] = 64'h9999; pend[1] = 1;
        step(1'b1);
        ta[1] = 5'd7; td[1] = 64'hAAAA_AAAA_AAAA_AAAA; pend[1] = 1;
        ta[2] = 5'd7; td[2] = 64'hBBBB_BBBB_BBBB_BBBB; pend[2] = 1;
        gq.delete();
        repeat (3) step(1'b1);
        check("same_addr_count", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            check("same_addr_first", 64'(gq[0]), 64'd2);
            check("same_addr_second", 64'(gq[1]), 64'd1);
        end
        check("reg7_final", rf_mem[7], 64'hAAAA_AAAA_AAAA_AAAA);

        // Async reset while a write is in the output stage.
        ta[0] = 5'd4; td[0] = 64'h4444; pend[0] = 1;
        step(1'b1);
        ta[1] = 5'd10; td[1] = 64'hA0; pend[1] = 1;
        ta[2] = 5'd11; td[2] = 64'hB0; pend[2] = 1;
        step(1'b0);
        step(1'b0);
        gq.delete();
        repeat (3) step(1'b1);
        check("post_reset_count", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            check("post_reset_first", 64'(gq[0]), 64'd1);
            check("post_reset_second", 64'(gq[1]), 64'd2);
        end

        // Request to address 31.
        ta[0] = 5'd31; td[0] = 64'h3131; pend[0] = 1;
        step(1'b1);
        check("xzr_ready", 64'(req_ready), 64'd1);
        step(1'b1);
`ifdef REGWR_XZR_DROP_EN
        check("xzr_rf_write", 64'(rf_write), 64'd0);
        check("xzr_busy31", 64'(busy[31]), 64'd0);
`else
        check("r31_rf_write", 64'(rf_write), 64'd1);
        check("r31_rf_address", 64'(rf_address), 64'd31);
`endif
        step(1'b1);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
